mod_reduction_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one modular-reduction adapter between `NREQ` requesters in the MSM datapath. Point-arithmetic units submit double-width products. The block grants one requester at a time and drives the adapter's `enable`/`a`. It waits for `done`, then returns the `width`-bit remainder to the granted requester. It is the only master of the adapter's input port.

---
 rtl/mod_reduction_arb_pkg.sv | 23 ++
 rtl/mod_reduction_rr_pick.sv | 45 ++++
 rtl/mod_reduction_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mod_reduction_arbiter.sv | 541 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_reduction_arb_pkg.sv
// Shared types and defaults for the modular-reduction arbiter.
// States, default sizing and the grant-index width helper live here so the
// picker and the top agree on them.
package mod_reduction_arb_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 128;
   localparam int DEF_OPW   = 2 * DEF_WIDTH;
   localparam int DEF_IDXW  = $clog2(DEF_NREQ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   // Grant-index width; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mod_reduction_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1 with wrap
// and returns the first valid requester as one-hot, index and an any flag.
module mod_reduction_rr_pick
   import mod_reduction_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDXW = idx_width(DEF_NREQ)
) (
   input  logic [NREQ-1:0] i_req_valid,
   input  logic [IDXW-1:0] i_last,
   output logic [NREQ-1:0] o_grant,
   output logic [IDXW-1:0] o_idx,
   output logic            o_any
);

   logic [NREQ-1:0] w_grant;
   logic [IDXW-1:0] w_idx;
   logic [IDXW-1:0] w_cand;
   logic            w_any;
   int              w_pos;

   // Walk candidates from farthest to nearest so the nearest valid one wins.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_any   = 1'b0;
      w_cand  = '0;
      w_pos   = 0;
      for (int k = NREQ; k >= 1; k--) begin
         w_pos  = (int'(i_last) + k) % NREQ;
         w_cand = IDXW'(w_pos);
         if (i_req_valid[w_cand]) begin
            w_grant         = '0;
            w_grant[w_cand] = 1'b1;
            w_idx           = w_cand;
            w_any           = 1'b1;
         end
      end
   end

   assign o_grant = w_grant;
   assign o_idx   = w_idx;
   assign o_any   = w_any;

endmodule

// File: rtl/mod_reduction_arbiter.sv
// Round-robin arbiter/sequencer in front of a single modular-reduction
// adapter. One operation in flight; operand and remainder pass through
// unmodified.
// Optional watchdog: define MOD_REDUCTION_ARB_TIMEOUT_EN to abort a WAIT
// that lasts TIMEOUT cycles, answer with a zero remainder and set sticky err.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | pick next requester, pulse req_ready, latch grant + operand
// ST_ISSUE | first cycle of red_enable with the latched operand
// ST_WAIT  | hold red_enable/red_a until red_done (or watchdog expiry)
// ST_RESP  | pulse rsp_valid to the granted requester, update last
module mod_reduction_arbiter
   import mod_reduction_arb_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = 255
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [NREQ-1:0]         i_req_valid,
   input  logic [NREQ*2*WIDTH-1:0] i_req_a,
   output logic [NREQ-1:0]         o_req_ready,
   output logic [NREQ-1:0]         o_rsp_valid,
   output logic [WIDTH-1:0]        o_rsp_r,
   output logic                    o_red_enable,
   output logic [2*WIDTH-1:0]      o_red_a,
   input  logic                    i_red_done,
   input  logic [WIDTH-1:0]        i_red_r,
   output logic                    o_busy,
   output logic                    o_err
);

   localparam int OPW  = 2 * WIDTH;
   localparam int IDXW = idx_width(NREQ);

   arb_state_e       r_state;
   arb_state_e       w_next;
   logic [IDXW-1:0]  r_gidx;
   logic [IDXW-1:0]  r_last;
   logic [OPW-1:0]   r_operand;
   logic [WIDTH-1:0] r_result;

   logic [NREQ-1:0]  w_pick_onehot;
   logic [IDXW-1:0]  w_pick_idx;
   logic             w_pick_any;
   logic             w_accept;
   logic             w_capture;
   logic             w_timeout;
   logic [NREQ-1:0]  w_req_ready;
   logic [NREQ-1:0]  w_rsp_valid;
   logic             w_red_enable;

   mod_reduction_rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .i_req_valid (i_req_valid),
      .i_last      (r_last),
      .o_grant     (w_pick_onehot),
      .o_idx       (w_pick_idx),
      .o_any       (w_pick_any)
   );

   // Next-state and handshake outputs; handshakes are gated while reset is
   // held so an aborted or not-yet-started operation never signals.
   always_comb begin
      w_next       = r_state;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_req_ready  = '0;
      w_rsp_valid  = '0;
      w_red_enable = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_any && i_reset) begin
               w_accept    = 1'b1;
               w_req_ready = w_pick_onehot;
               w_next      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_red_enable = 1'b1;
            w_next       = ST_WAIT;
         end
         ST_WAIT: begin
            w_red_enable = 1'b1;
            if (i_red_done) begin
               w_capture = 1'b1;
               w_next    = ST_RESP;
            end else if (w_timeout) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (i_reset) begin
               w_rsp_valid[r_gidx] = 1'b1;
            end
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State, grant/operand latch, result capture and round-robin pointer.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state   <= ST_IDLE;
         r_gidx    <= '0;
         r_last    <= IDXW'(NREQ - 1);
         r_operand <= '0;
         r_result  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_gidx    <= w_pick_idx;
            r_operand <= i_req_a[w_pick_idx*OPW +: OPW];
         end
         if (w_capture) begin
            r_result <= i_red_r;
         end else if (w_timeout) begin
            r_result <= '0;
         end
         if (r_state == ST_RESP) begin
            r_last <= r_gidx;
         end
      end
   end

`ifdef MOD_REDUCTION_ARB_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);

   logic [WDW-1:0] r_wdog;
   logic           r_err;

   // Watchdog down-counter: loaded in ISSUE, expires on the TIMEOUT-th WAIT
   // cycle without red_done; err stays set until reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == ST_ISSUE) begin
            r_wdog <= WDW'(TIMEOUT - 1);
         end else if ((r_state == ST_WAIT) && (r_wdog != '0)) begin
            r_wdog <= r_wdog - 1'b1;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign w_timeout = (r_state == ST_WAIT) && (r_wdog == '0) && !i_red_done;
   assign o_err     = r_err;
`else
   assign w_timeout = 1'b0;
   assign o_err     = 1'b0;
`endif

   assign o_req_ready  = w_req_ready;
   assign o_rsp_valid  = w_rsp_valid;
   assign o_rsp_r      = r_result;
   assign o_red_enable = w_red_enable;
   assign o_red_a      = r_operand;
   assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mod_reduction_arbiter.sv
// Bench for mod_reduction_arbiter: adapter model returns a mod 37 after a
// programmable latency; requesters drop (or refill) on acceptance; expected
// grants come from a round-robin pointer model kept here.
module tb_mod_reduction_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 128;
   localparam int OPW   = 2 * WIDTH;
`ifdef MOD_REDUCTION_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*OPW-1:0]   req_a;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_r;
   logic                  red_enable;
   logic [OPW-1:0]        red_a;
   logic                  red_done;
   logic [WIDTH-1:0]      red_r;
   logic                  busy;
   logic                  err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_last = NREQ - 1;

   int   lat    = 3;
   bit   hang   = 1'b0;
   bit   spur   = 1'b0;
   bit   refill = 1'b0;
   int   en_cnt = 0;
   logic [NREQ-1:0] acc_q = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mod_reduction_arbiter #(
      .NREQ    (NREQ),
      .WIDTH   (WIDTH),
      .TIMEOUT (TO)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_req_valid  (req_valid),
      .i_req_a      (req_a),
      .o_req_ready  (req_ready),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_r      (rsp_r),
      .o_red_enable (red_enable),
      .o_red_a      (red_a),
      .i_red_done   (red_done),
      .i_red_r      (red_r),
      .o_busy       (busy),
      .o_err        (err)
   );

   // Adapter model: done on the (lat+1)-th enable cycle, r = a mod 37.
   always @(negedge clk) begin
      #3;
      if (red_enable === 1'b1) en_cnt++;
      else en_cnt = 0;
      red_done = spur | (!hang && (red_enable === 1'b1) && (en_cnt == lat + 1));
      red_r    = WIDTH'(red_a % 37);
   end

   // Requesters: remember accepts mid-cycle, drop or refill after the edge.
   always @(negedge clk) begin
      #2;
      acc_q = req_ready;
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acc_q[i] === 1'b1) begin
            if (refill) req_a[i*OPW +: OPW] = rand_op();
            else        req_valid[i] = 1'b0;
         end
      end
      acc_q = '0;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit: got=running want=finished");
      $fatal(1, "time limit");
   end

   function automatic logic [OPW-1:0] rand_op();
      logic [OPW-1:0] v;
      for (int i = 0; i < OPW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] ref_mod(input logic [OPW-1:0] a);
      return WIDTH'(a % 37);
   endfunction

   // Round-robin rule: first valid requester after last, with wrap.
   function automatic int rr_next(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (last + k) % NREQ;
         if (((v >> c) & 1) != 0) return c;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int g);
      logic [NREQ-1:0] v;
      v = '0;
      if (g >= 0) v = NREQ'(1) << g;
      return v;
   endfunction

   // Enter at a falling edge; returns at falling edge + 1 of the accept cycle.
   task automatic wait_ready(input int budget, output int t, output bit ok);
      ok = 1'b0;
      t  = -1;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (req_ready !== '0) begin
            ok = 1'b1;
            t  = cyc;
            return;
         end
         @(negedge clk);
      end
   endtask

   // Steps cycle by cycle after an accept; tracks operand/enable stability.
   task automatic wait_rsp(input int budget, input logic [OPW-1:0] a_exp,
                           output int t, output bit ok, output bit stable);
      ok     = 1'b0;
      stable = 1'b1;
      t      = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (rsp_valid !== '0) begin
            ok = 1'b1;
            t  = cyc;
            return;
         end
         if (red_enable !== 1'b1 || red_a !== a_exp || busy !== 1'b1) stable = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b0;
      req_valid = '0;
      refill    = 1'b0;
      hang      = 1'b0;
      spur      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset    = 1'b1;
      exp_last = NREQ - 1;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      @(negedge clk);
      @(negedge clk);
      req_valid = '1;
      #1;
      total++;
      if (req_ready !== '0 || rsp_valid !== '0) begin
         bad++;
         $display("FAIL reset_handshake: ready=%b rsp=%b want=0/0", req_ready, rsp_valid);
      end
      total++;
      if (red_enable !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: en=%b busy=%b err=%b want=0", red_enable, busy, err);
      end
      total++;
      if (rsp_r !== '0 || red_a !== '0) begin
         bad++;
         $display("FAIL reset_data: rsp_r=%h red_a=%h want=0", rsp_r, red_a);
      end
      req_valid = '0;
      @(negedge clk);
      reset    = 1'b1;
      exp_last = NREQ - 1;
   endtask

   task automatic test_single();
      int t, t2;
      bit ok, ok2, st;
      do_reset();
      lat = 3;
      req_a[2*OPW +: OPW] = OPW'(1000);
      req_valid = 4'b0100;
      wait_ready(10, t, ok);
      total++;
      if (!ok || req_ready !== 4'b0100 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_ready: ready=%b busy=%b want=0100/0", req_ready, busy);
      end
      wait_rsp(20, OPW'(1000), t2, ok2, st);
      total++;
      if (!ok2 || rsp_valid !== 4'b0100 || rsp_r !== WIDTH'(1)) begin
         bad++;
         $display("FAIL single_rsp: valid=%b r=%0d want=0100/1", rsp_valid, rsp_r);
      end
      total++;
      if (t2 != t + 5 || !st || red_enable !== 1'b0) begin
         bad++;
         $display("FAIL single_timing: rsp_at=%0d stable=%0d en=%b want=%0d/1/0",
                  t2 - t, st, red_enable, 5);
      end
      exp_last = 2;
      @(negedge clk);
      #1;
      total++;
      if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_once: ready=%b rsp=%b busy=%b want=0", req_ready, rsp_valid, busy);
      end
   endtask

   task automatic test_fairness();
      int t, t2, prev;
      bit ok, ok2, st;
      logic [OPW-1:0] a;
      do_reset();
      for (int i = 0; i < NREQ; i++) req_a[i*OPW +: OPW] = rand_op();
      refill    = 1'b1;
      req_valid = '1;
      prev      = -1;
      for (int k = 0; k < 6; k++) begin
         lat = $urandom_range(1, 4);
         wait_ready(12, t, ok);
         a = req_a[(k % NREQ)*OPW +: OPW];
         total++;
         if (!ok || req_ready !== onehot(k % NREQ)) begin
            bad++;
            $display("FAIL fair_grant%0d: ready=%b want=%b", k, req_ready, onehot(k % NREQ));
         end
         if (prev >= 0) begin
            total++;
            if (t != prev + 1) begin
               bad++;
               $display("FAIL fair_b2b%0d: gap=%0d want=1", k, t - prev);
            end
         end
         wait_rsp(20, a, t2, ok2, st);
         total++;
         if (!ok2 || rsp_valid !== onehot(k % NREQ) || rsp_r !== ref_mod(a)
             || t2 != t + lat + 2 || !st) begin
            bad++;
            $display("FAIL fair_rsp%0d: valid=%b r=%h lat=%0d st=%0d want=%b/%h/%0d/1",
                     k, rsp_valid, rsp_r, t2 - t, st, onehot(k % NREQ), ref_mod(a), lat + 2);
         end
         prev = t2;
      end
      req_valid = '0;
      refill    = 1'b0;
      exp_last  = 1;
   endtask

   task automatic test_random();
      int t, t2, prev, g;
      bit ok, ok2, st;
      logic [OPW-1:0] a;
      do_reset();
      prev = -1;
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] !== 1'b1 && $urandom_range(0, 1) == 1) begin
               req_a[i*OPW +: OPW] = rand_op();
               req_valid[i] = 1'b1;
            end else if (req_valid[i] === 1'b1 && $urandom_range(0, 7) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         if (req_valid == '0) begin
            int i0;
            i0 = $urandom_range(0, NREQ - 1);
            req_a[i0*OPW +: OPW] = rand_op();
            req_valid[i0] = 1'b1;
         end
         lat = $urandom_range(1, 5);
         g   = rr_next(req_valid, exp_last);
         a   = req_a[g*OPW +: OPW];
         wait_ready(12, t, ok);
         total++;
         if (!ok || req_ready !== onehot(g)) begin
            bad++;
            $display("FAIL rand_grant%0d: ready=%b want=%b", n, req_ready, onehot(g));
         end
         if (prev >= 0) begin
            total++;
            if (t != prev + 1) begin
               bad++;
               $display("FAIL rand_b2b%0d: gap=%0d want=1", n, t - prev);
            end
         end
         wait_rsp(20, a, t2, ok2, st);
         total++;
         if (!ok2 || rsp_valid !== onehot(g) || rsp_r !== ref_mod(a)) begin
            bad++;
            $display("FAIL rand_rsp%0d: valid=%b r=%h want=%b/%h", n, rsp_valid, rsp_r,
                     onehot(g), ref_mod(a));
         end
         total++;
         if (t2 != t + lat + 2 || !st || red_enable !== 1'b0) begin
            bad++;
            $display("FAIL rand_timing%0d: lat=%0d st=%0d en=%b want=%0d/1/0",
                     n, t2 - t, st, red_enable, lat + 2);
         end
         exp_last = g;
         prev     = t2;
      end
      req_valid = '0;
`ifndef MOD_REDUCTION_ARB_TIMEOUT_EN
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL rand_err: err=%b want=0", err);
      end
`endif
   endtask

   task automatic test_spurious();
      int seen;
      do_reset();
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (rsp_valid !== '0 || busy !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL spurious_done: bad_cycles=%0d want=0", seen);
      end
   endtask

   task automatic test_mid_reset();
      int t, t2;
      bit ok, ok2, st;
      logic [OPW-1:0] a;
      do_reset();
      lat = 1;
      a   = rand_op();
      req_a[1*OPW +: OPW] = a;
      req_valid = 4'b0010;
      wait_ready(10, t, ok);
      wait_rsp(20, a, t2, ok2, st);
      total++;
      if (!ok2 || rsp_valid !== 4'b0010 || rsp_r !== ref_mod(a)) begin
         bad++;
         $display("FAIL midrst_pre: valid=%b r=%h want=0010/%h", rsp_valid, rsp_r, ref_mod(a));
      end
      lat = 6;
      req_a[2*OPW +: OPW] = rand_op();
      req_valid = 4'b0100;
      wait_ready(10, t, ok);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (req_ready !== '0 || rsp_valid !== '0 || red_enable !== 1'b0 || busy !== 1'b0
          || rsp_r !== '0 || red_a !== '0) begin
         bad++;
         $display("FAIL midrst_outputs: rdy=%b rsp=%b en=%b busy=%b r=%h a=%h want=all0",
                  req_ready, rsp_valid, red_enable, busy, rsp_r, red_a);
      end
      reset = 1'b1;
      exp_last = NREQ - 1;
      lat = 2;
      a = rand_op();
      req_a[0] = 1'b0;
      req_a[0*OPW +: OPW] = a;
      req_a[2*OPW +: OPW] = rand_op();
      req_a[3*OPW +: OPW] = rand_op();
      req_valid = 4'b1101;
      wait_ready(10, t, ok);
      total++;
      if (!ok || req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL midrst_next_grant: ready=%b want=0001", req_ready);
      end
      wait_rsp(20, a, t2, ok2, st);
      total++;
      if (!ok2 || rsp_valid !== 4'b0001 || rsp_r !== ref_mod(a)) begin
         bad++;
         $display("FAIL midrst_no_stale_rsp: valid=%b r=%h want=0001/%h", rsp_valid, rsp_r,
                  ref_mod(a));
      end
      req_valid = '0;
      exp_last  = 0;
   endtask

   task automatic test_withdraw();
      int t, t2, hits0, hits1;
      bit ok, ok2, st;
      logic [OPW-1:0] a;
      do_reset();
      lat = 4;
      req_a[0*OPW +: OPW] = rand_op();
      req_a[1*OPW +: OPW] = rand_op();
      req_valid = 4'b0011;
      wait_ready(10, t, ok);
      total++;
      if (!ok || req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL withdraw_first: ready=%b want=0001", req_ready);
      end
      @(negedge clk);
      req_valid[1] = 1'b0;
      hits0 = 0;
      hits1 = 0;
      for (int i = 0; i < 15; i++) begin
         #1;
         if (req_ready[1] === 1'b1 || rsp_valid[1] === 1'b1) hits1++;
         if (rsp_valid[0] === 1'b1) hits0++;
         @(negedge clk);
      end
      total++;
      if (hits1 != 0 || hits0 != 1) begin
         bad++;
         $display("FAIL withdraw_req1: req1_events=%0d req0_rsps=%0d want=0/1", hits1, hits0);
      end
      exp_last = 0;
      lat = 1;
      a = rand_op();
      req_a[3*OPW +: OPW] = a;
      req_valid = 4'b1000;
      wait_ready(10, t, ok);
      wait_rsp(20, a, t2, ok2, st);
      total++;
      if (!ok || !ok2 || rsp_valid !== 4'b1000 || rsp_r !== ref_mod(a)) begin
         bad++;
         $display("FAIL withdraw_after: valid=%b r=%h want=1000/%h", rsp_valid, rsp_r, ref_mod(a));
      end
      exp_last = 3;
   endtask

`ifdef MOD_REDUCTION_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int t, t2;
      bit ok, ok2, st;
      logic [OPW-1:0] a;
      do_reset();
      hang = 1'b1;
      a = rand_op();
      req_a[2*OPW +: OPW] = a;
      req_valid = 4'b0100;
      wait_ready(10, t, ok);
      wait_rsp(40, a, t2, ok2, st);
      total++;
      if (!ok2 || t2 != t + 10 || rsp_valid !== 4'b0100 || rsp_r !== '0) begin
         bad++;
         $display("FAIL timeout_rsp: at=%0d valid=%b r=%h want=10/0100/0", t2 - t, rsp_valid, rsp_r);
      end
      total++;
      if (err !== 1'b1 || !st) begin
         bad++;
         $display("FAIL timeout_err: err=%b stable=%0d want=1/1", err, st);
      end
      hang = 1'b0;
      lat  = 2;
      exp_last = 2;
      @(negedge clk);
      a = rand_op();
      req_a[0*OPW +: OPW] = a;
      req_valid = 4'b0001;
      wait_ready(10, t, ok);
      wait_rsp(20, a, t2, ok2, st);
      total++;
      if (!ok2 || rsp_valid !== 4'b0001 || rsp_r !== ref_mod(a) || err !== 1'b1) begin
         bad++;
         $display("FAIL timeout_after: valid=%b r=%h err=%b want=0001/%h/1",
                  rsp_valid, rsp_r, err, ref_mod(a));
      end
   endtask
`else
   task automatic test_no_timeout();
      int t, hits;
      bit ok;
      do_reset();
      hang = 1'b1;
      req_a[1*OPW +: OPW] = rand_op();
      req_valid = 4'b0010;
      wait_ready(10, t, ok);
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (rsp_valid !== '0 || red_enable !== 1'b1 || err !== 1'b0) hits++;
      end
      total++;
      if (!ok || hits != 0) begin
         bad++;
         $display("FAIL no_timeout_wait: accepted=%0d bad_cycles=%0d want=1/0", ok, hits);
      end
      hang = 1'b0;
   endtask
`endif

   initial begin
      red_done = 1'b0;
      red_r    = '0;
      test_reset();
      test_single();
      test_fairness();
      test_random();
      test_spurious();
      test_mid_reset();
      test_withdraw();
`ifdef MOD_REDUCTION_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
